cby_param_shadow: RTL
=====================

Name: cby_param_shadow

Overview:
- Parametrised Y-direction connection block, the next generation of the fixed-width cby tiles.
- Passes CHAN_W vertical tracks straight through in both directions.
- Drives NUM_IPIN grid input pins, each through a MUX_SIZE:1 routing mux.
- Mux selects come from a double-buffered configuration chain: a shift register loaded over prog_clk, copied to an active register only on cfg_load, so the routing can be reconfigured without glitches.

Parameters:
CHAN_W, 30, tracks per direction
NUM_IPIN, 4, grid input pins driven
MUX_SIZE, 12, mux inputs per ipin; must be even and >= 2
STRIDE, 3, track step between successive input pairs
SEL_W, $clog2(MUX_SIZE), select bits per ipin (derived)
CFG_BITS, NUM_IPIN*SEL_W, chain length (derived)

Ports:
prog_clk  in  1  configuration/register clock
pReset  in  1  reset; asynchronous, active-low
ccff_en  in  1  shift enable for the configuration chain
ccff_head  in  1  serial configuration data in
cfg_load  in  1  copy the shift chain into the active selects
chany_bottom_in  in  CHAN_W  tracks entering from below
chany_top_in  in  CHAN_W  tracks entering from above
chany_bottom_out  out  CHAN_W  equals chany_top_in (combinational)
chany_top_out  out  CHAN_W  equals chany_bottom_in (combinational)
ipin_out  out  NUM_IPIN  muxed grid input pins
ccff_tail  out  1  serial data out, equals sr[CFG_BITS-1]
cfg_done  out  1  a full CFG_BITS has been shifted since the last load/reset
cfg_count  out  $clog2(CFG_BITS+1)  bits shifted since the last load/reset; saturates at CFG_BITS

Behaviour:
- Reset (pReset low, asynchronous):
  - sr, active, cfg_count clear to 0; cfg_done = 0; ccff_tail = 0.
  - ipin_out[k] = chany_bottom_in[k mod CHAN_W].
- Mux input map, ipin k, j = 0..MUX_SIZE/2-1:
  - t = (k + j*STRIDE) mod CHAN_W.
  - in[2j] = chany_bottom_in[t]; in[2j+1] = chany_top_in[t].
- Select: sel_k = active[k*SEL_W +: SEL_W], binary encoded.
  - ipin_out[k] = in[sel_k] combinationally.
  - If sel_k >= MUX_SIZE, ipin_out[k] = 0.
- Shift: on a prog_clk rising edge with ccff_en = 1, sr <= {sr[CFG_BITS-2:0], ccff_head}.
  - The first bit shifted in ends at sr[CFG_BITS-1], the MSB of ipin NUM_IPIN-1.
- Load: on a prog_clk rising edge with cfg_load = 1, active <= sr (value before this edge's shift); cfg_count <= 0.
- cfg_load and ccff_en together: active takes the pre-shift sr, sr shifts, cfg_count <= 1.
- cfg_count increments per enabled shift and saturates at CFG_BITS (no wrap).
- cfg_done = (cfg_count == CFG_BITS), registered output.
- Extra shifts past CFG_BITS keep shifting: bits continue out of ccff_tail so tiles can be daisy-chained. Count stays saturated.
- active never changes except on load or reset. Shifting never disturbs ipin_out.
- Reset mid-shift: chain content is lost and everything returns to the reset state. The next configuration restarts from count 0.
- Latency: pass-through and mux paths are 0-cycle combinational. The select update is visible 1 edge after cfg_load.

Decomposition:
- Package cby_pkg holds:
  - function track_idx(k, j, STRIDE, CHAN_W);
  - localparam helpers for SEL_W and CFG_BITS;
  - typedef for the sel field.
- One sub-module, cby_ipin_mux: a MUX_SIZE:1 binary-select mux with out-of-range → 0, instantiated NUM_IPIN times.
- The chain, shadow register and counter stay in the top level.

Test Plan (defaults, CFG_BITS = 16):
- Reset: pReset low with chany_bottom_in = 30'h1 → ipin_out = 4'b0001; cfg_count = 0; ccff_tail = 0. Release with no activity → outputs unchanged.
- Shift then load:
  - Shift 16 bits MSB-first: ipin3 = 0, ipin2 = 0, ipin1 = 5, ipin0 = 0.
  - cfg_done rises after the 16th shift; ipin_out is unchanged before cfg_load.
  - After load, ipin1 follows chany_top_in[7] (toggle it 0→1→0 and check).
- Out-of-range select: load ipin2 = 4'd13 → ipin_out[2] = 0 for all track values.
- Overflow/daisy-chain: shift 20 bits → cfg_count stays 16. ccff_tail emits the first 4 shifted bits on shifts 17-20, in order.
- Load+shift same edge: sr = 16'hA5A5, ccff_head = 1, both asserted → active = 16'hA5A5, sr = 16'h4B4B, cfg_count = 1.
- Mid-config reset: shift 8 bits, pulse pReset low → sr = 0, cfg_count = 0, active = 0. A following full 16-bit configuration works normally.

Source files
------------

// File: rtl/cby_param_shadow_pkg.sv
// Shared types and helpers for the parametrised Y connection block.
// Track mapping and configuration sizing live here.
package cby_pkg;

    localparam int DEF_CHAN_W   = 30;
    localparam int DEF_NUM_IPIN = 4;
    localparam int DEF_MUX_SIZE = 12;
    localparam int DEF_STRIDE   = 3;

    function automatic int sel_width(input int mux_size);
        return (mux_size < 2) ? 1 : $clog2(mux_size);
    endfunction

    function automatic int cfg_width(input int num_ipin,
                                     input int mux_size);
        return num_ipin * sel_width(mux_size);
    endfunction

    function automatic int cnt_width(input int cfg_bits);
        return $clog2(cfg_bits + 1);
    endfunction

    function automatic int track_idx(input int k,
                                     input int j,
                                     input int stride,
                                     input int chan_w);
        return (k + j * stride) % chan_w;
    endfunction

    localparam int DEF_SEL_W = sel_width(DEF_MUX_SIZE);
    localparam int DEF_CFG_BITS =
        cfg_width(DEF_NUM_IPIN, DEF_MUX_SIZE);
    localparam int DEF_CNT_W = cnt_width(DEF_CFG_BITS);

    typedef logic [DEF_SEL_W-1:0] sel_t;

endpackage

// File: rtl/cby_param_shadow_if.sv
// Channel and configuration-chain bundle for cby_param_shadow.
// master drives tracks and chain inputs; slave is the tile.
interface cby_param_shadow_if #(
    parameter int CHAN_W   = 30,
    parameter int NUM_IPIN = 4,
    parameter int CNT_W    = 5
);
    logic              ccff_en;
    logic              ccff_head;
    logic              cfg_load;
    logic [CHAN_W-1:0] chany_bottom_in;
    logic [CHAN_W-1:0] chany_top_in;
    logic [CHAN_W-1:0] chany_bottom_out;
    logic [CHAN_W-1:0] chany_top_out;
    logic [NUM_IPIN-1:0] ipin_out;
    logic              ccff_tail;
    logic              cfg_done;
    logic [CNT_W-1:0]  cfg_count;

    modport master (
        output ccff_en, ccff_head, cfg_load,
        output chany_bottom_in, chany_top_in,
        input  chany_bottom_out, chany_top_out,
        input  ipin_out, ccff_tail, cfg_done, cfg_count
    );

    modport slave (
        input  ccff_en, ccff_head, cfg_load,
        input  chany_bottom_in, chany_top_in,
        output chany_bottom_out, chany_top_out,
        output ipin_out, ccff_tail, cfg_done, cfg_count
    );
endinterface

// File: rtl/cby_param_shadow_ipin_mux.sv
// Binary-select routing mux for one grid input pin.
// Selects beyond the populated inputs drive a constant 0.
module cby_ipin_mux #(
    parameter int MUX_SIZE = 12,
    parameter int SEL_W    = 4
) (
    input  logic [MUX_SIZE-1:0] in_i,
    input  logic [SEL_W-1:0]    sel_i,
    output logic                out_o
);
    always_comb begin
        out_o = 1'b0;
        if (32'(sel_i) < MUX_SIZE) begin
            out_o = in_i[sel_i];
        end
    end
endmodule

// File: rtl/cby_param_shadow.sv
// Y connection block with a double-buffered select chain:
// shift register over prog_clk, copied to active on cfg_load.
module cby_param_shadow
    import cby_pkg::*;
#(
    parameter int CHAN_W   = DEF_CHAN_W,
    parameter int NUM_IPIN = DEF_NUM_IPIN,
    parameter int MUX_SIZE = DEF_MUX_SIZE,
    parameter int STRIDE   = DEF_STRIDE
) (
    input logic prog_clk,
    input logic pReset,
    cby_param_shadow_if.slave bus
);
    localparam int SEL_W    = sel_width(MUX_SIZE);
    localparam int CFG_BITS = cfg_width(NUM_IPIN, MUX_SIZE);
    localparam int CNT_W    = cnt_width(CFG_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

    logic [CFG_BITS-1:0] sr_q, sr_d;
    logic [CFG_BITS-1:0] active_q, active_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                done_q;
    logic [NUM_IPIN-1:0] ipin;

    always_comb begin
        sr_d     = sr_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        if (bus.ccff_en) begin
            sr_d = {sr_q[CFG_BITS-2:0], bus.ccff_head};
        end
        // Load sees the pre-shift chain; a same-edge shift counts as 1
        if (bus.cfg_load) begin
            active_d = sr_q;
            cnt_d    = bus.ccff_en ? CNT_W'(1) : '0;
        end else if (bus.ccff_en && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr_q     <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            done_q   <= (cnt_d == CNT_MAX);
        end
    end

    for (genvar k = 0; k < NUM_IPIN; k++) begin : g_ipin
        logic [MUX_SIZE-1:0] mux_in;
        for (genvar j = 0; j < MUX_SIZE / 2; j++) begin : g_in
            localparam int T = track_idx(k, j, STRIDE, CHAN_W);
            assign mux_in[2*j]   = bus.chany_bottom_in[T];
            assign mux_in[2*j+1] = bus.chany_top_in[T];
        end
        cby_ipin_mux #(
            .MUX_SIZE (MUX_SIZE),
            .SEL_W    (SEL_W)
        ) u_mux (
            .in_i  (mux_in),
            .sel_i (active_q[k*SEL_W +: SEL_W]),
            .out_o (ipin[k])
        );
    end

    assign bus.chany_bottom_out = bus.chany_top_in;
    assign bus.chany_top_out    = bus.chany_bottom_in;
    assign bus.ipin_out         = ipin;
    assign bus.ccff_tail        = sr_q[CFG_BITS-1];
    assign bus.cfg_done         = done_q;
    assign bus.cfg_count        = cnt_q;
endmodule
